avmm_reg32_slave: RTL and testbench

Avalon-MM slave front-end that sits directly upstream of the 32-bit byte-enabled data register. It accepts one bus transfer at a time and inserts configurable write wait states. It legalises byte enables and drives the register's data and byte-enable inputs for exactly one cycle per accepted write. It also returns read data from the register and from local status/counter registers.

---
 rtl/avmm_reg32_slave.sv | 90 +++++++++
 tb/tb_avmm_reg32_slave.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/avmm_reg32_slave.sv
// avmm_reg32_slave: Avalon-MM front-end for a 32-bit byte-enabled data register, with write wait states and local status/count registers.
module avmm_reg32_slave #(
  parameter int WAIT_CYCLES = 1,
  parameter int CNT_W = 8
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [1:0]  avs_address,
  input  logic        avs_write,
  input  logic        avs_read,
  input  logic [31:0] avs_writedata,
  input  logic [3:0]  avs_byteenable,
  output logic [31:0] avs_readdata,
  output logic        avs_waitrequest,
  output logic [31:0] reg_D,
  output logic [3:0]  reg_byteenable,
  input  logic [31:0] reg_Q
);
  typedef enum logic [1:0] {IDLE, WAIT, COMMIT, RD} state_t;
  state_t state, next;
  logic [1:0] cap_addr;
  logic [31:0] cap_data, d_hold, wr_count, rd_mux;
  logic [3:0] cap_be, cnt;
  logic [CNT_W-1:0] illegal_cnt;
  logic err_sticky, legal, wr_ok, wr_bad, clr, rd_go;
  assign legal = cap_be inside {4'b1111, 4'b0011, 4'b1100, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
  assign wr_ok = state == COMMIT && cap_addr == 2'd0 && legal;
  assign wr_bad = state == COMMIT && cap_addr == 2'd0 && !legal;
  assign clr = state == COMMIT && cap_addr == 2'd3 && cap_be[0] && cap_data[0];
  assign rd_go = state == IDLE && avs_read && !avs_write;
  // Data output is a pass-through of the captured word in the commit cycle and the last committed word otherwise.
  assign reg_D = wr_ok ? cap_data : d_hold;
  assign reg_byteenable = wr_ok ? cap_be : 4'b0000;
  assign avs_waitrequest = !(state == COMMIT || state == RD);
  always_comb begin
    rd_mux = 32'd0;
    case (avs_address)
      2'd0: rd_mux = reg_Q;
      2'd1: rd_mux = {16'd0, 8'(illegal_cnt), 7'd0, err_sticky};
      2'd2: rd_mux = wr_count;
      default: rd_mux = 32'd0;
    endcase
  end
  always_comb begin
    next = state;
    case (state)
      IDLE: next = avs_write ? (WAIT_CYCLES == 0 ? COMMIT : WAIT) : avs_read ? RD : IDLE;
      WAIT: next = cnt == 4'd0 ? COMMIT : WAIT;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cap_addr <= 2'd0;
      cap_data <= 32'd0;
      cap_be <= 4'd0;
      cnt <= 4'd0;
      d_hold <= 32'd0;
      avs_readdata <= 32'd0;
      wr_count <= 32'd0;
      illegal_cnt <= '0;
      err_sticky <= 1'b0;
    end else begin
      state <= next;
      if (state == IDLE && avs_write) begin
        cap_addr <= avs_address;
        cap_data <= avs_writedata;
        cap_be <= avs_byteenable;
        cnt <= 4'(WAIT_CYCLES - 1);
      end else if (rd_go) begin
        cap_addr <= avs_address;
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (rd_go) avs_readdata <= rd_mux;
      if (wr_ok) begin
        d_hold <= cap_data;
        wr_count <= wr_count + 32'd1;
      end
      if (wr_bad) begin
        err_sticky <= 1'b1;
        if (illegal_cnt != '1) illegal_cnt <= illegal_cnt + 1'b1;
      end else if (clr) begin
        err_sticky <= 1'b0;
        illegal_cnt <= '0;
      end
    end
  end
endmodule

// File: tb/tb_avmm_reg32_slave.sv
// tb_avmm_reg32_slave: scoreboard bench for avmm_reg32_slave with a behavioural byte-enabled register downstream.
module tb_avmm_reg32_slave;
  localparam int W = 1;
  logic clock = 1'b0, reset_n = 1'b0;
  logic [1:0] avs_address = 2'd0;
  logic avs_write = 1'b0, avs_read = 1'b0;
  logic [31:0] avs_writedata = 32'd0, avs_readdata, reg_D, reg_Q;
  logic [3:0] avs_byteenable = 4'd0, reg_byteenable;
  logic avs_waitrequest;
  int n_checks = 0, n_errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] m_q = 0, m_d = 0, m_wr = 0, last_rd = 0;
  logic [7:0] m_cnt = 0;
  logic m_err = 0;

  always #5 clock = ~clock;

  avmm_reg32_slave #(.WAIT_CYCLES(W), .CNT_W(8)) dut (
    .clock(clock), .reset_n(reset_n), .avs_address(avs_address), .avs_write(avs_write),
    .avs_read(avs_read), .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable),
    .avs_readdata(avs_readdata), .avs_waitrequest(avs_waitrequest), .reg_D(reg_D),
    .reg_byteenable(reg_byteenable), .reg_Q(reg_Q)
  );

  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) reg_Q <= 32'd0;
    else for (int i = 0; i < 4; i++) if (reg_byteenable[i]) reg_Q[8*i +: 8] <= reg_D[8*i +: 8];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic is_legal(input logic [3:0] be);
    return be == 4'hF || be == 4'h3 || be == 4'hC || be == 4'h1 || be == 4'h2 || be == 4'h4 || be == 4'h8;
  endfunction

  task automatic do_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] be, input logic also_rd);
    int n = 0;
    logic ok;
    ok = a == 2'd0 && is_legal(be);
    avs_address = a; avs_writedata = d; avs_byteenable = be; avs_write = 1'b1; avs_read = also_rd;
    while (n < 40) begin
      @(negedge clock);
      n++;
      if (!avs_waitrequest) break;
      check("be_quiet", {28'd0, reg_byteenable}, 32'd0);
    end
    check("wr_latency", 32'(n), 32'(W + 1));
    check("commit_be", {28'd0, reg_byteenable}, ok ? {28'd0, be} : 32'd0);
    check("commit_d", reg_D, ok ? d : m_d);
    if (also_rd) check("no_rd_data", avs_readdata, last_rd);
    avs_write = 1'b0; avs_read = 1'b0;
    if (a == 2'd0) begin
      if (ok) begin
        for (int i = 0; i < 4; i++) if (be[i]) m_q[8*i +: 8] = d[8*i +: 8];
        m_d = d;
        m_wr = m_wr + 1;
      end else begin
        m_err = 1'b1;
        if (m_cnt != 8'hFF) m_cnt = m_cnt + 1;
      end
    end else if (a == 2'd3 && be[0] && d[0]) begin
      m_err = 1'b0;
      m_cnt = 8'd0;
    end
    @(negedge clock);
  endtask

  task automatic do_read(input logic [1:0] a);
    int n = 0;
    logic [31:0] e;
    case (a)
      2'd0: exp_q.push_back(m_q);
      2'd1: exp_q.push_back({16'd0, m_cnt, 7'd0, m_err});
      2'd2: exp_q.push_back(m_wr);
      default: exp_q.push_back(32'd0);
    endcase
    avs_address = a; avs_read = 1'b1;
    while (n < 40) begin
      @(negedge clock);
      n++;
      if (!avs_waitrequest) break;
    end
    check("rd_latency", 32'(n), 32'd1);
    e = exp_q.pop_front();
    check($sformatf("rd_addr%0d", a), avs_readdata, e);
    last_rd = avs_readdata;
    avs_read = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    repeat (2) @(negedge clock);
    check("rst_wait", {31'd0, avs_waitrequest}, 32'd1);
    check("rst_be", {28'd0, reg_byteenable}, 32'd0);
    check("rst_d", reg_D, 32'd0);
    check("rst_rd", avs_readdata, 32'd0);
    reset_n = 1'b1;
    @(negedge clock);
    do_write(2'd0, 32'hDEADBEEF, 4'hF, 1'b0);
    do_read(2'd0);
    do_read(2'd2);
    do_write(2'd0, 32'h0, 4'hF, 1'b0);
    do_write(2'd0, 32'h12345678, 4'h3, 1'b0);
    do_write(2'd0, 32'hAA000000, 4'h8, 1'b0);
    do_read(2'd0);
    check("merge_const", m_q, 32'hAA005678);
    do_write(2'd0, 32'hFFFFFFFF, 4'h5, 1'b0);
    do_read(2'd0);
    do_read(2'd1);
    do_write(2'd0, 32'h0, 4'h0, 1'b0);
    do_write(2'd0, 32'h0, 4'h7, 1'b0);
    for (int i = 0; i < 300; i++) begin
      avs_address = 2'd0; avs_writedata = 32'($urandom); avs_byteenable = 4'h5; avs_write = 1'b1;
      repeat (W + 2) @(negedge clock);
      avs_write = 1'b0;
      @(negedge clock);
    end
    m_cnt = 8'hFF;
    do_read(2'd1);
    check("sat_const", {16'd0, m_cnt, 7'd0, m_err}, 32'h0000FF01);
    do_write(2'd3, 32'h1, 4'h2, 1'b0);
    do_read(2'd1);
    do_write(2'd1, 32'hFFFFFFFF, 4'hF, 1'b0);
    do_write(2'd2, 32'hFFFFFFFF, 4'hF, 1'b0);
    do_read(2'd2);
    do_write(2'd3, 32'h1, 4'h1, 1'b0);
    do_read(2'd1);
    do_read(2'd3);
    do_write(2'd0, 32'h0BADF00D, 4'hC, 1'b1);
    do_read(2'd0);
    force dut.wr_count = 32'hFFFFFFFF;
    @(negedge clock);
    release dut.wr_count;
    m_wr = 32'hFFFFFFFF;
    do_read(2'd2);
    do_write(2'd0, 32'h01020304, 4'hF, 1'b0);
    do_read(2'd2);
    // Abort a write while it is still in its wait state.
    avs_address = 2'd0; avs_writedata = 32'h55555555; avs_byteenable = 4'hF; avs_write = 1'b1;
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("abort_wait", {31'd0, avs_waitrequest}, 32'd1);
    check("abort_be", {28'd0, reg_byteenable}, 32'd0);
    @(negedge clock);
    check("abort_be2", {28'd0, reg_byteenable}, 32'd0);
    avs_write = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    m_q = 0; m_d = 0; m_wr = 0; m_cnt = 0; m_err = 0;
    @(negedge clock);
    do_read(2'd0);
    do_read(2'd2);
    do_read(2'd1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
